// File: rtl/apb_regbank_ws.sv
// apb_regbank_ws: parametrised APB slave register bank with wait-state insertion,
// byte-strobed writes, PSLVERR address decode and per-register write pulses.
module apb_regbank_ws #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned N_CTRL   = 4,
   parameter int unsigned N_STAT   = 2,
   parameter int unsigned WAIT_CYC = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     PSEL,
   input  logic                     PEN,
   input  logic                     PW,
   input  logic [ADDR_W-1:0]        PADDR,
   input  logic [DATA_W-1:0]        PWDATA,
   input  logic [DATA_W/8-1:0]      PSTRB,
   output logic                     PREADY,
   output logic [DATA_W-1:0]        PRDATA,
   output logic                     PSLVERR,
   output logic [N_CTRL*DATA_W-1:0] ctrl_q,
   output logic [N_CTRL-1:0]        ctrl_wr_pulse,
   input  logic [N_STAT*DATA_W-1:0] stat_d,
   input  logic [N_STAT-1:0]        stat_we
);

   localparam int unsigned NB        = DATA_W / 8;
   localparam int unsigned N_REG     = N_CTRL + N_STAT;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYC);

   generate
      if ((DATA_W % 8) != 0 || DATA_W == 0)
         $error("apb_regbank_ws: DATA_W must be a non-zero multiple of 8");
      if (WAIT_CYC > 15)
         $error("apb_regbank_ws: WAIT_CYC must be in 0..15");
      if (ADDR_W < 32 && N_REG > (32'd1 << ADDR_W))
         $error("apb_regbank_ws: N_CTRL+N_STAT exceeds the PADDR space");
   endgenerate

   typedef enum logic {
      IDLE,
      ACCESS
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] ctrl_reg_q [N_CTRL];
   logic [DATA_W-1:0] ctrl_reg_d [N_CTRL];
   logic [DATA_W-1:0] stat_reg_q [N_STAT];
   logic [N_CTRL-1:0] pulse_q, pulse_d;
   logic [31:0]       paddr_ext;
   logic              addr_err;
   logic              commit;
   logic [DATA_W-1:0] rd_sel;

   assign paddr_ext = 32'(PADDR);
   assign addr_err  = (paddr_ext >= N_REG) || (PW && (paddr_ext >= N_CTRL));

   // A PSEL seen in IDLE (with or without PEN) starts the wait countdown.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      PREADY  = 1'b0;
      case (state_q)
         IDLE: begin
            if (PSEL) begin
               state_d = ACCESS;
               cnt_d   = WAIT_INIT;
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (PEN) begin
               PREADY  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign PSLVERR = PREADY & addr_err;
   assign commit  = PREADY & PW & ~addr_err;

   always_comb begin
      rd_sel = '0;
      for (int unsigned i = 0; i < N_CTRL; i++) begin
         if (paddr_ext == i) rd_sel = ctrl_reg_q[i];
      end
      for (int unsigned j = 0; j < N_STAT; j++) begin
         if (paddr_ext == N_CTRL + j) rd_sel = stat_reg_q[j];
      end
   end

   assign PRDATA = (PREADY && !PW && !addr_err) ? rd_sel : '0;

   always_comb begin
      pulse_d = '0;
      for (int unsigned i = 0; i < N_CTRL; i++) begin
         ctrl_reg_d[i] = ctrl_reg_q[i];
         if (commit && paddr_ext == i) begin
            pulse_d[i] = 1'b1;
            for (int unsigned k = 0; k < NB; k++) begin
               if (PSTRB[k]) ctrl_reg_d[i][8*k +: 8] = PWDATA[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pulse_q <= '0;
         for (int unsigned i = 0; i < N_CTRL; i++) ctrl_reg_q[i] <= '0;
         for (int unsigned j = 0; j < N_STAT; j++) stat_reg_q[j] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         for (int unsigned i = 0; i < N_CTRL; i++) ctrl_reg_q[i] <= ctrl_reg_d[i];
         for (int unsigned j = 0; j < N_STAT; j++) begin
            if (stat_we[j]) stat_reg_q[j] <= stat_d[j*DATA_W +: DATA_W];
         end
      end
   end

   for (genvar g = 0; g < N_CTRL; g++) begin : g_ctrl_out
      assign ctrl_q[g*DATA_W +: DATA_W] = ctrl_reg_q[g];
   end

   assign ctrl_wr_pulse = pulse_q;

endmodule

// File: tb/tb_apb_regbank_ws.sv
// Self-checking bench for apb_regbank_ws: directed scenarios plus randomized APB
// traffic compared every cycle against a register-array model of the bank.
module tb_apb_regbank_ws;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 8;
   localparam int unsigned NC = 4;
   localparam int unsigned NS = 2;
   localparam int unsigned WC = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             PSEL, PEN, PW;
   logic [AW-1:0]    PADDR;
   logic [DW-1:0]    PWDATA;
   logic [DW/8-1:0]  PSTRB;
   logic             PREADY;
   logic [DW-1:0]    PRDATA;
   logic             PSLVERR;
   logic [NC*DW-1:0] ctrl_q;
   logic [NC-1:0]    ctrl_wr_pulse;
   logic [NS*DW-1:0] stat_d;
   logic [NS-1:0]    stat_we;

   always #5 clk = ~clk;

   apb_regbank_ws #(
      .DATA_W(DW), .ADDR_W(AW), .N_CTRL(NC), .N_STAT(NS), .WAIT_CYC(WC)
   ) dut (
      .clk(clk), .rst(rst), .PSEL(PSEL), .PEN(PEN), .PW(PW), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
      .PSLVERR(PSLVERR), .ctrl_q(ctrl_q), .ctrl_wr_pulse(ctrl_wr_pulse),
      .stat_d(stat_d), .stat_we(stat_we)
   );

   int checks = 0;
   int errors = 0;

   logic [DW-1:0]    ctrl_m [NC];
   logic [DW-1:0]    stat_m [NS];
   logic             exp_ready, exp_err;
   logic [DW-1:0]    exp_rdata;
   logic [NC-1:0]    exp_pulse;
   logic [NC*DW-1:0] exp_ctrl;
   logic             chk_en = 1'b0;
   logic             rand_stat = 1'b0;
   logic             commit_pend;
   int unsigned      commit_a;
   logic [DW-1:0]    commit_wd;
   logic [3:0]       commit_st;
   int unsigned      ready_idx;
   logic [DW-1:0]    last_rdata;
   logic             last_err;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_err(input logic w, input int unsigned a);
      return (a >= NC + NS) || (w && a >= NC);
   endfunction

   function automatic logic [DW-1:0] model_read(input int unsigned a);
      if (a < NC) return ctrl_m[a];
      if (a < NC + NS) return stat_m[a-NC];
      return '0;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NC; i++) ctrl_m[i] = '0;
      for (int j = 0; j < NS; j++) stat_m[j] = '0;
      exp_pulse   = '0;
      commit_pend = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NC; i++) exp_ctrl[i*DW +: DW] = ctrl_m[i];
         check("PREADY", 128'(PREADY), 128'(exp_ready));
         check("PSLVERR", 128'(PSLVERR), 128'(exp_err));
         check("PRDATA", 128'(PRDATA), 128'(exp_rdata));
         check("ctrl_wr_pulse", 128'(ctrl_wr_pulse), 128'(exp_pulse));
         check("ctrl_q", 128'(ctrl_q), 128'(exp_ctrl));
      end
   end

   // Model state advances at each rising edge using the inputs held through that cycle.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         clear_model();
      end else begin
         for (int j = 0; j < NS; j++) if (stat_we[j]) stat_m[j] = stat_d[j*DW +: DW];
         exp_pulse = '0;
         if (commit_pend) begin
            for (int k = 0; k < 4; k++)
               if (commit_st[k]) ctrl_m[commit_a][8*k +: 8] = commit_wd[8*k +: 8];
            exp_pulse[commit_a] = 1'b1;
            commit_pend = 1'b0;
         end
      end
      #1;
   endtask

   task automatic drive_stat();
      if (rand_stat) begin
         stat_we = 2'($urandom_range(0, 3));
         stat_d  = {$urandom, $urandom};
      end else begin
         stat_we = '0;
      end
   endtask

   task automatic set_quiet_exp();
      exp_ready = 1'b0;
      exp_err   = 1'b0;
      exp_rdata = '0;
   endtask

   task automatic idle_cyc();
      PSEL = 1'b0; PEN = 1'b0; PW = 1'($urandom);
      PADDR = AW'($urandom); PWDATA = $urandom; PSTRB = 4'($urandom);
      drive_stat();
      set_quiet_exp();
      tick();
   endtask

   task automatic stat_load(input logic [DW-1:0] v);
      PSEL = 1'b0; PEN = 1'b0;
      stat_we = 2'b01; stat_d[DW-1:0] = v;
      set_quiet_exp();
      tick();
      stat_we = '0;
   endtask

   task automatic xfer(input logic w, input int unsigned a, input logic [DW-1:0] wd,
                       input logic [3:0] st, input int unsigned abort_at,
                       input logic st_on_rdy, input logic [DW-1:0] st_val);
      ready_idx = 0;
      PSEL = 1'b1; PEN = 1'b0; PW = w; PADDR = AW'(a); PWDATA = wd; PSTRB = st;
      drive_stat();
      set_quiet_exp();
      tick();
      for (int unsigned k = 1; k <= WC + 1; k++) begin
         PEN = 1'b1;
         drive_stat();
         set_quiet_exp();
         if (k == abort_at) begin
            PSEL = 1'b0; PEN = 1'b0;
            tick();
            return;
         end
         if (k == WC + 1) begin
            if (st_on_rdy) begin
               stat_we = 2'b01; stat_d[DW-1:0] = st_val;
            end
            exp_ready = 1'b1;
            exp_err   = model_err(w, a);
            exp_rdata = (!w && !exp_err) ? model_read(a) : '0;
            if (w && !exp_err) begin
               commit_pend = 1'b1; commit_a = a; commit_wd = wd; commit_st = st;
            end
         end
         @(negedge clk);
         if (PREADY === 1'b1 && ready_idx == 0) ready_idx = k;
         last_rdata = PRDATA;
         last_err   = PSLVERR;
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int unsigned a, ab;
      rst = 1'b0; PSEL = 1'b0; PEN = 1'b0; PW = 1'b0; PADDR = '0;
      PWDATA = '0; PSTRB = '0; stat_we = '0; stat_d = '0;
      clear_model();
      set_quiet_exp();
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;

      // Reset held: bus activity and status loads must not leak through.
      for (int i = 0; i < 6; i++) begin
         PSEL = 1'($urandom); PEN = 1'($urandom); PW = 1'($urandom);
         PADDR = AW'($urandom_range(0, 7)); PWDATA = $urandom; PSTRB = '1;
         stat_we = '1; stat_d = {$urandom, $urandom};
         set_quiet_exp();
         tick();
      end
      check("rst_ctrl_q", 128'(ctrl_q), 128'(0));
      check("rst_pready", 128'(PREADY), 128'(0));
      check("rst_prdata", 128'(PRDATA), 128'(0));
      check("rst_pslverr", 128'(PSLVERR), 128'(0));
      stat_we = '0;
      rst = 1'b1;
      repeat (3) idle_cyc();
      check("post_rst_ctrl_q", 128'(ctrl_q), 128'(0));

      xfer(1'b1, 1, 32'hDEADBEEF, 4'hF, 0, 1'b0, '0);
      check("wait2_latency", 128'(ready_idx), 128'(3));
      check("ctrl1_full", 128'(ctrl_q[63:32]), 128'(32'hDEADBEEF));
      check("pulse_after_wr", 128'(ctrl_wr_pulse), 128'(4'b0010));
      idle_cyc();
      check("pulse_one_cycle", 128'(ctrl_wr_pulse), 128'(4'b0000));

      xfer(1'b1, 1, 32'h0000AA00, 4'b0010, 0, 1'b0, '0);
      check("ctrl1_byte1", 128'(ctrl_q[63:32]), 128'(32'hDEADAAEF));
      xfer(1'b0, 1, '0, 4'h0, 0, 1'b0, '0);
      check("rd_ctrl1", 128'(last_rdata), 128'(32'hDEADAAEF));
      check("rd_ctrl1_err", 128'(last_err), 128'(0));

      xfer(1'b1, 2, 32'h12345678, 4'h0, 0, 1'b0, '0);
      check("strb0_pulse", 128'(ctrl_wr_pulse), 128'(4'b0100));
      check("strb0_value", 128'(ctrl_q[95:64]), 128'(0));

      stat_load(32'h12345678);
      xfer(1'b0, 4, '0, 4'h0, 0, 1'b0, '0);
      check("rd_stat0", 128'(last_rdata), 128'(32'h12345678));
      xfer(1'b0, 4, '0, 4'h0, 0, 1'b1, 32'hCAFEF00D);
      check("rd_stat0_old", 128'(last_rdata), 128'(32'h12345678));
      xfer(1'b0, 4, '0, 4'h0, 0, 1'b0, '0);
      check("rd_stat0_new", 128'(last_rdata), 128'(32'hCAFEF00D));

      xfer(1'b1, 4, 32'hFFFFFFFF, 4'hF, 0, 1'b0, '0);
      check("wr_stat_err", 128'(last_err), 128'(1));
      check("wr_stat_nopulse", 128'(ctrl_wr_pulse), 128'(0));
      xfer(1'b0, 4, '0, 4'h0, 0, 1'b0, '0);
      check("stat_unchanged", 128'(last_rdata), 128'(32'hCAFEF00D));
      xfer(1'b0, 9, '0, 4'h0, 0, 1'b0, '0);
      check("rd_oob_err", 128'(last_err), 128'(1));
      check("rd_oob_data", 128'(last_rdata), 128'(0));

      xfer(1'b1, 3, 32'h0BADF00D, 4'hF, 1, 1'b0, '0);
      idle_cyc();
      check("abort_no_write", 128'(ctrl_q[127:96]), 128'(0));

      // Reset dropped in the second wait cycle of a write to reg 0.
      xfer(1'b1, 0, 32'h11111111, 4'hF, 0, 1'b0, '0);
      PSEL = 1'b1; PEN = 1'b0; PW = 1'b1; PADDR = '0; PWDATA = 32'hA5A5A5A5; PSTRB = '1;
      set_quiet_exp();
      tick();
      PEN = 1'b1;
      tick();
      rst = 1'b0;
      clear_model();
      tick();
      PSEL = 1'b0; PEN = 1'b0;
      tick();
      rst = 1'b1;
      idle_cyc();
      check("rst_mid_ctrl0", 128'(ctrl_q[31:0]), 128'(0));
      xfer(1'b1, 0, 32'h5A5A5A5A, 4'hF, 0, 1'b0, '0);
      check("after_rst_latency", 128'(ready_idx), 128'(3));
      check("after_rst_ctrl0", 128'(ctrl_q[31:0]), 128'(32'h5A5A5A5A));

      rand_stat = 1'b1;
      for (int n = 0; n < 400; n++) begin
         repeat ($urandom_range(0, 2)) idle_cyc();
         a  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
         ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, WC) : 0;
         xfer(1'($urandom), a, $urandom, 4'($urandom), ab, 1'b0, '0);
      end
      idle_cyc();
      chk_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
